// File: rtl/sdr_wb_bridge_if.sv
// ---------------------------------------------------------------------------
// sdr_wb_bridge_if
// Wishbone classic bus between a bus master and the SDRAM bridge.
//   wb_cyc_i / wb_stb_i / wb_we_i : cycle, strobe, write flag (master -> bridge)
//   wb_sel_i[3:0]                 : byte enables
//   wb_adr_i[31:0]                : byte address
//   wb_dat_i[31:0]                : write data
//   wb_ack_o                      : one-cycle acknowledge (bridge -> master)
//   wb_dat_o[31:0]                : read data
// ---------------------------------------------------------------------------
interface sdr_wb_bridge_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic        wb_ack_o;
    logic [31:0] wb_dat_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        input  wb_ack_o, wb_dat_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        output wb_ack_o, wb_dat_o
    );
endinterface

// File: rtl/sdr_wb_bridge.sv
// ---------------------------------------------------------------------------
// sdr_wb_bridge
// Wishbone classic slave in front of an SDRAM controller. Full-word writes
// are posted through a 4-entry FIFO and acked immediately; reads and
// partial writes (read-modify-write) are serviced by an engine once the FIFO
// has drained, which keeps controller-side ordering equal to bus ordering.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   wb              : Wishbone slave modport (see sdr_wb_bridge_if)
//   ctl_addr[22:0]  : controller byte address, bits [1:0] always 0
//   ctl_rw          : 1 = write, 0 = read
//   ctl_data_in     : write data to controller
//   ctl_in_valid    : one-cycle request pulse
//   ctl_busy        : controller not ready
//   ctl_data_out    : read data from controller
//   ctl_out_valid   : read data valid pulse
//   rd_err          : sticky read-timeout flag
// ---------------------------------------------------------------------------
module sdr_wb_bridge #(
    parameter logic [31:0] BASE_ADDR  = 32'h3800_0000,
    parameter logic [7:0]  RD_TIMEOUT = 8'd255
) (
    input  logic             clk,
    input  logic             rst,
    sdr_wb_bridge_if.slave   wb,
    output logic [22:0]      ctl_addr,
    output logic             ctl_rw,
    output logic [31:0]      ctl_data_in,
    output logic             ctl_in_valid,
    input  logic             ctl_busy,
    input  logic [31:0]      ctl_data_out,
    input  logic             ctl_out_valid,
    output logic             rd_err
);
    typedef enum logic [2:0] {IDLE, GAP, RD_WAIT, RMW_WAIT, RMW_WR, ACK} state_t;
    typedef enum logic [1:0] {OP_WR, OP_RD, OP_RMW} op_t;

    function automatic logic [31:0] byte_merge(input logic [31:0] mem_word,
                                               input logic [31:0] wr_word,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        for (int i = 0; i < 4; i++)
            res[8*i +: 8] = sel[i] ? wr_word[8*i +: 8] : mem_word[8*i +: 8];
        return res;
    endfunction

    state_t      state, state_nxt;
    op_t         op;
    logic [7:0]  tmo_cnt;
    logic        abandon;

    logic [52:0] fifo_mem [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic        fifo_full, fifo_empty;

    logic [31:0] req_dat, merge_dat;
    logic [3:0]  req_sel;

    logic hit, full_wr, push, svc_req;
    logic pop, issue_rd, rd_cap, rmw_cap, tmo_hit, tmo_run, rmw_issue, ack_go;
    logic unused_adr;

    assign unused_adr = ^wb.wb_adr_i[1:0];

    assign hit     = wb.wb_cyc_i & wb.wb_stb_i & (wb.wb_adr_i[31:23] == BASE_ADDR[31:23]);
    assign full_wr = wb.wb_we_i & (wb.wb_sel_i == 4'hF);
    // While wb_ack_o is high the master still presents the acked request.
    assign push    = hit & full_wr & ~fifo_full & ~wb.wb_ack_o;
    assign svc_req = hit & ~full_wr & fifo_empty & ~ctl_busy & ~wb.wb_ack_o;

    // Write FIFO: pointers and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            fifo_full  <= 1'b0;
            fifo_empty <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10: begin
                    fifo_empty <= 1'b0;
                    fifo_full  <= ((wr_ptr + 2'd1) == rd_ptr);
                end
                2'b01: begin
                    fifo_full  <= 1'b0;
                    fifo_empty <= ((rd_ptr + 2'd1) == wr_ptr);
                end
                default: ;
            endcase
        end
    end

    // Data-only storage, no reset needed
    always_ff @(posedge clk) begin
        if (push)     fifo_mem[wr_ptr] <= {wb.wb_adr_i[22:2], wb.wb_dat_i};
        if (issue_rd) begin
            req_dat <= wb.wb_dat_i;
            req_sel <= wb.wb_sel_i;
        end
        if (rmw_cap)  merge_dat <= byte_merge(ctl_data_out, req_dat, req_sel);
    end

    // Engine state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Engine next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if ((~fifo_empty & ~ctl_busy) | svc_req) state_nxt = GAP;
            end
            GAP: begin
                case (op)
                    OP_RD:   state_nxt = ctl_out_valid ? ACK : RD_WAIT;
                    OP_RMW:  state_nxt = ctl_out_valid ? RMW_WR : RMW_WAIT;
                    default: state_nxt = IDLE;
                endcase
            end
            RD_WAIT: begin
                if (ctl_out_valid | (tmo_cnt == RD_TIMEOUT)) state_nxt = ACK;
            end
            RMW_WAIT: begin
                if (ctl_out_valid)                state_nxt = RMW_WR;
                else if (tmo_cnt == RD_TIMEOUT)   state_nxt = ACK;
            end
            RMW_WR: begin
                if (~ctl_busy) state_nxt = ACK;
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Engine output strobes
    always_comb begin
        pop       = 1'b0;
        issue_rd  = 1'b0;
        rd_cap    = 1'b0;
        rmw_cap   = 1'b0;
        tmo_hit   = 1'b0;
        tmo_run   = 1'b0;
        rmw_issue = 1'b0;
        case (state)
            IDLE: begin
                pop      = ~fifo_empty & ~ctl_busy;
                issue_rd = svc_req;
            end
            GAP: begin
                rd_cap  = ctl_out_valid & (op == OP_RD);
                rmw_cap = ctl_out_valid & (op == OP_RMW);
            end
            RD_WAIT, RMW_WAIT: begin
                rd_cap  = ctl_out_valid & (state == RD_WAIT);
                rmw_cap = ctl_out_valid & (state == RMW_WAIT);
                tmo_hit = ~ctl_out_valid & (tmo_cnt == RD_TIMEOUT);
                tmo_run = ~ctl_out_valid & (tmo_cnt != RD_TIMEOUT);
            end
            RMW_WR:  rmw_issue = ~ctl_busy;
            default: ;
        endcase
        ack_go = (state_nxt == ACK);
    end

    // Registered bus and controller outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            wb.wb_ack_o  <= 1'b0;
            wb.wb_dat_o  <= 32'h0;
            ctl_in_valid <= 1'b0;
            ctl_rw       <= 1'b0;
            ctl_addr     <= 23'h0;
            ctl_data_in  <= 32'h0;
            rd_err       <= 1'b0;
            tmo_cnt      <= 8'h0;
            op           <= OP_WR;
            abandon      <= 1'b0;
        end else begin
            // A dropped cycle still finishes on the controller side but never acks.
            wb.wb_ack_o  <= push | (ack_go & ~abandon & wb.wb_cyc_i);
            ctl_in_valid <= pop | issue_rd | rmw_issue;
            if (pop) begin
                ctl_addr    <= {fifo_mem[rd_ptr][52:32], 2'b00};
                ctl_rw      <= 1'b1;
                ctl_data_in <= fifo_mem[rd_ptr][31:0];
                op          <= OP_WR;
            end
            if (issue_rd) begin
                ctl_addr <= {wb.wb_adr_i[22:2], 2'b00};
                ctl_rw   <= 1'b0;
                op       <= wb.wb_we_i ? OP_RMW : OP_RD;
                tmo_cnt  <= 8'h0;
                abandon  <= 1'b0;
            end else begin
                if (state != IDLE && !wb.wb_cyc_i) abandon <= 1'b1;
                if (tmo_run) tmo_cnt <= tmo_cnt + 8'd1;
            end
            if (rmw_issue) begin
                ctl_rw      <= 1'b1;
                ctl_data_in <= merge_dat;
            end
            if (rd_cap) wb.wb_dat_o <= ctl_data_out;
            if (tmo_hit) begin
                rd_err <= 1'b1;
                if (op == OP_RD) wb.wb_dat_o <= 32'hDEAD_BEEF;
            end
        end
    end
endmodule

// File: tb/tb_sdr_wb_bridge.sv
// ---------------------------------------------------------------------------
// tb_sdr_wb_bridge
// Directed bench for sdr_wb_bridge: a Wishbone master task, a behavioural
// SDRAM controller (memory, programmable read latency, request log) and
// hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_sdr_wb_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic [22:0] ctl_addr;
    logic        ctl_rw;
    logic [31:0] ctl_data_in;
    logic        ctl_in_valid;
    logic        ctl_busy;
    logic [31:0] ctl_data_out;
    logic        ctl_out_valid;
    logic        rd_err;

    always #5 clk = ~clk;

    sdr_wb_bridge_if bus ();

    sdr_wb_bridge dut (
        .clk           (clk),
        .rst           (rst),
        .wb            (bus),
        .ctl_addr      (ctl_addr),
        .ctl_rw        (ctl_rw),
        .ctl_data_in   (ctl_data_in),
        .ctl_in_valid  (ctl_in_valid),
        .ctl_busy      (ctl_busy),
        .ctl_data_out  (ctl_data_out),
        .ctl_out_valid (ctl_out_valid),
        .rd_err        (rd_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural controller
    logic [22:0] log_addr [$];
    logic        log_rw   [$];
    logic [31:0] log_data [$];
    logic [31:0] mem [logic [22:0]];
    int          ack_cnt  = 0;
    int          resp_lat = 2;
    bit          resp_en  = 1'b1;
    int          cnt      = 0;
    logic [31:0] rd_val   = 32'h0;

    initial begin
        ctl_out_valid = 1'b0;
        ctl_data_out  = 32'h0;
        forever begin
            @(negedge clk);
            ctl_out_valid = 1'b0;
            if (rst) cnt = 0;
            if (bus.wb_ack_o) ack_cnt++;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    ctl_out_valid = 1'b1;
                    ctl_data_out  = rd_val;
                end
            end
            if (ctl_in_valid) begin
                log_addr.push_back(ctl_addr);
                log_rw.push_back(ctl_rw);
                log_data.push_back(ctl_data_in);
                if (ctl_rw) mem[ctl_addr] = ctl_data_in;
                else if (resp_en) begin
                    rd_val = mem.exists(ctl_addr) ? mem[ctl_addr] : 32'h0;
                    if (resp_lat == 0) begin
                        ctl_out_valid = 1'b1;
                        ctl_data_out  = rd_val;
                    end else cnt = resp_lat;
                end
            end
        end
    end

    // One Wishbone classic transfer; holds the request through the ack edge.
    task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                           input logic [31:0] dat, input int max_cyc,
                           output bit acked, output int lat, output logic [31:0] rdata);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_sel_i = sel;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
        acked = 1'b0;
        lat   = 0;
        rdata = 32'h0;
        while (!acked && lat < max_cyc) begin
            @(posedge clk); #1;
            lat++;
            if (bus.wb_ack_o) begin
                acked = 1'b1;
                rdata = bus.wb_dat_o;
            end
        end
        if (acked) begin
            @(posedge clk); #1;
        end
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit          acked;
        int          lat;
        logic [31:0] rdata;
        int          base;
        int          a0;

        rst          = 1'b1;
        ctl_busy     = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_sel_i = 4'h0;
        bus.wb_adr_i = 32'h0;
        bus.wb_dat_i = 32'h0;
        tick(3);

        chk("rst_ack",      bus.wb_ack_o, 0);
        chk("rst_dat",      bus.wb_dat_o, 0);
        chk("rst_in_valid", ctl_in_valid, 0);
        chk("rst_rw",       ctl_rw, 0);
        chk("rst_addr",     ctl_addr, 0);
        chk("rst_wdata",    ctl_data_in, 0);
        chk("rst_rd_err",   rd_err, 0);
        rst = 1'b0;
        tick(1);

        // Single posted write
        base = log_addr.size();
        wb_xfer(32'h3800_0010, 1'b1, 4'hF, 32'h1234_5678, 10, acked, lat, rdata);
        chk("wr_ack", acked, 1);
        chk("wr_lat", lat, 1);
        tick(5);
        chk("wr_issued", log_addr.size() - base, 1);
        if (log_addr.size() > base) begin
            chk("wr_addr",  log_addr[base], 23'h10);
            chk("wr_rw",    log_rw[base], 1);
            chk("wr_wdata", log_data[base], 32'h1234_5678);
        end

        // Five writes with the controller busy: four fill the FIFO, fifth stalls
        ctl_busy = 1'b1;
        base = log_addr.size();
        for (int i = 0; i < 4; i++) begin
            wb_xfer(32'h3800_0020 + 32'(4 * i), 1'b1, 4'hF, 32'hA000_0000 + 32'(i), 10,
                    acked, lat, rdata);
            chk("fill_ack", acked, 1);
            chk("fill_lat", lat, 1);
        end
        chk("fill_none_issued", log_addr.size() - base, 0);
        fork
            wb_xfer(32'h3800_0030, 1'b1, 4'hF, 32'hA000_0004, 40, acked, lat, rdata);
            begin
                tick(5);
                ctl_busy = 1'b0;
            end
        join
        chk("stall_ack", acked, 1);
        chk("stall_lat_ge6", lat >= 6, 1);
        tick(20);
        chk("drain_count", log_addr.size() - base, 5);
        if (log_addr.size() >= base + 5) begin
            for (int i = 0; i < 5; i++) begin
                chk("drain_addr",  log_addr[base + i], 23'h20 + 23'(4 * i));
                chk("drain_wdata", log_data[base + i], 32'hA000_0000 + 32'(i));
            end
        end

        // Write then read of the same address while the write is still queued
        base = log_addr.size();
        a0 = ack_cnt;
        ctl_busy = 1'b1;
        wb_xfer(32'h3800_0040, 1'b1, 4'hF, 32'hCAFE_0001, 10, acked, lat, rdata);
        chk("wr_a_ack", acked, 1);
        fork
            wb_xfer(32'h3800_0040, 1'b0, 4'hF, 32'h0, 60, acked, lat, rdata);
            begin
                tick(3);
                ctl_busy = 1'b0;
            end
        join
        chk("rd_a_ack", acked, 1);
        chk("rd_a_data", rdata, 32'hCAFE_0001);
        tick(3);
        chk("rd_a_acks", ack_cnt - a0, 2);
        chk("rd_a_count", log_addr.size() - base, 2);
        if (log_addr.size() >= base + 2) begin
            chk("rd_a_first_is_wr", log_rw[base], 1);
            chk("rd_a_second_is_rd", log_rw[base + 1], 0);
            chk("rd_a_addr", log_addr[base + 1], 23'h40);
        end

        // Read data returned while the engine is still in the gap cycle
        resp_lat = 0;
        wb_xfer(32'h3800_0040, 1'b0, 4'hF, 32'h0, 30, acked, lat, rdata);
        chk("rd_fast_ack", acked, 1);
        chk("rd_fast_data", rdata, 32'hCAFE_0001);
        resp_lat = 2;
        tick(2);

        // Partial write: read-modify-write of byte 1
        mem[23'h80] = 32'h1122_3344;
        base = log_addr.size();
        a0 = ack_cnt;
        wb_xfer(32'h3800_0080, 1'b1, 4'b0010, 32'h0000_AB00, 60, acked, lat, rdata);
        chk("rmw_ack", acked, 1);
        tick(5);
        chk("rmw_acks", ack_cnt - a0, 1);
        chk("rmw_count", log_addr.size() - base, 2);
        if (log_addr.size() >= base + 2) begin
            chk("rmw_rd", log_rw[base], 0);
            chk("rmw_wr", log_rw[base + 1], 1);
            chk("rmw_addr", log_addr[base + 1], 23'h80);
            chk("rmw_wdata", log_data[base + 1], 32'h1122_AB44);
        end

        // Master drops the cycle mid-read: controller read completes, no ack
        resp_lat = 6;
        base = log_addr.size();
        a0 = ack_cnt;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b0;
        bus.wb_sel_i = 4'hF;
        bus.wb_adr_i = 32'h3800_0044;
        tick(3);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        tick(15);
        chk("drop_issued", log_addr.size() - base, 1);
        chk("drop_no_ack", ack_cnt - a0, 0);
        resp_lat = 2;
        wb_xfer(32'h3800_0040, 1'b0, 4'hF, 32'h0, 30, acked, lat, rdata);
        chk("after_drop_ack", acked, 1);
        chk("after_drop_data", rdata, 32'hCAFE_0001);

        // Outside the decoded window
        base = log_addr.size();
        wb_xfer(32'h3000_0000, 1'b0, 4'hF, 32'h0, 20, acked, lat, rdata);
        chk("oow_rd_ack", acked, 0);
        wb_xfer(32'h3000_0000, 1'b1, 4'hF, 32'h5555_AAAA, 20, acked, lat, rdata);
        chk("oow_wr_ack", acked, 0);
        tick(5);
        chk("oow_issued", log_addr.size() - base, 0);

        // Read timeout
        resp_en = 1'b0;
        wb_xfer(32'h3800_0100, 1'b0, 4'hF, 32'h0, 400, acked, lat, rdata);
        chk("tmo_ack", acked, 1);
        chk("tmo_data", rdata, 32'hDEAD_BEEF);
        chk("tmo_lat_ge256", lat >= 256, 1);
        chk("tmo_rd_err", rd_err, 1);
        resp_en = 1'b1;
        wb_xfer(32'h3800_0040, 1'b0, 4'hF, 32'h0, 30, acked, lat, rdata);
        chk("post_tmo_data", rdata, 32'hCAFE_0001);
        chk("rd_err_sticky", rd_err, 1);

        rst = 1'b1;
        tick(1);
        chk("rst_clears_rd_err", rd_err, 0);
        rst = 1'b0;
        tick(1);

        // Read-modify-write timeout: ack without the write
        resp_en = 1'b0;
        base = log_addr.size();
        wb_xfer(32'h3800_0080, 1'b1, 4'b0001, 32'h0000_00EE, 400, acked, lat, rdata);
        chk("rmw_tmo_ack", acked, 1);
        tick(5);
        chk("rmw_tmo_only_read", log_addr.size() - base, 1);
        chk("rmw_tmo_rd_err", rd_err, 1);
        resp_en = 1'b1;

        // Reset with queued writes discards them
        ctl_busy = 1'b1;
        wb_xfer(32'h3800_0200, 1'b1, 4'hF, 32'h0000_0001, 10, acked, lat, rdata);
        wb_xfer(32'h3800_0204, 1'b1, 4'hF, 32'h0000_0002, 10, acked, lat, rdata);
        base = log_addr.size();
        rst = 1'b1;
        tick(2);
        chk("mid_rst_ack", bus.wb_ack_o, 0);
        chk("mid_rst_rd_err", rd_err, 0);
        rst = 1'b0;
        ctl_busy = 1'b0;
        tick(10);
        chk("mid_rst_discard", log_addr.size() - base, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sdr_wb_bridge.md
SDR_WB_BRIDGE -- requirements
Module: sdr_wb_bridge

Interface
REQ-001 Parameter BASE_ADDR, default 32'h3800_0000: decoded window base; bits [31:23] are compared.
REQ-002 Parameter RD_TIMEOUT, default 8'd255: maximum cycles to wait for read data.
REQ-003 Reset rst, synchronous, active-high; clock clk.
REQ-004 clk  input  1  clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 wb_cyc_i, wb_stb_i, wb_we_i  input  1 each  Wishbone classic cycle, strobe and write flag.
REQ-007 wb_sel_i  input  4  byte enables; wb_adr_i  input  32  byte address; wb_dat_i  input  32  write data.
REQ-008 wb_ack_o  output  1  one-cycle acknowledge; wb_dat_o  output  32  read data.
REQ-009 ctl_addr  output  23  byte address to the controller, bits [1:0] always 0.
REQ-010 ctl_rw  output  1  1=write, 0=read; ctl_data_in  output  32  write data to the controller.
REQ-011 ctl_in_valid  output  1  one-cycle request pulse; ctl_busy  input  1  controller not ready.
REQ-012 ctl_data_out  input  32  read data; ctl_out_valid  input  1  read data valid pulse.
REQ-013 rd_err  output  1  sticky read-timeout flag.

Function
REQ-014 The bridge SHALL select a request when wb_cyc_i & wb_stb_i & (wb_adr_i[31:23]==BASE_ADDR[31:23]); requests outside the window are never acked.
REQ-015 The bridge SHALL hold a 4-entry write FIFO of {addr[22:2], data} with full and empty flags and 2-bit wrapping pointers.
REQ-016 A full-word write (sel==4'hF) SHALL be pushed when the FIFO is not full; wb_ack_o pulses the following cycle.
REQ-017 When the FIFO is full, a push SHALL NOT occur even if a pop happens in the same cycle; the request stalls.
REQ-018 A single request SHALL be pushed and acked once only; a new push requires the ack to have completed.
REQ-019 Engine states SHALL be IDLE, GAP, RD_WAIT, RMW_WAIT, RMW_WR and ACK.
REQ-020 IDLE: if the FIFO is non-empty and ctl_busy==0, the engine SHALL pop the FIFO, drive ctl_rw=1 with the address and data, pulse ctl_in_valid, and go to GAP.
REQ-021 IDLE: a read or partial write SHALL be serviced only when the FIFO is empty and ctl_busy==0; FIFO drain has priority so ordering is preserved.
REQ-022 Read: the engine SHALL issue ctl_rw=0 and ctl_in_valid, then wait in RD_WAIT.
REQ-023 GAP lasts exactly 1 cycle, during which ctl_busy SHALL be ignored; it returns to IDLE after a write and to RD_WAIT/RMW_WAIT after a read.
REQ-024 ctl_addr, ctl_rw and ctl_data_in SHALL change only on the cycle ctl_in_valid is asserted, and stay stable otherwise.
REQ-025 RD_WAIT: on ctl_out_valid the engine SHALL capture ctl_data_out into wb_dat_o and go to ACK, which pulses wb_ack_o for 1 cycle and returns to IDLE.
REQ-026 ctl_out_valid SHALL be accepted as early as the cycle after ctl_in_valid; a hit can return in 1 cycle, so the wait states check ctl_out_valid in GAP as well.
REQ-027 Partial write (sel!=4'hF, we=1): read, then in RMW_WAIT capture data and merge per byte (sel[n] selects wb_dat_i byte n), then RMW_WR issues a write when ctl_busy==0, then ACK.
REQ-028 A timeout counter (8-bit) SHALL run in RD_WAIT/RMW_WAIT; at RD_TIMEOUT the engine SHALL set rd_err=1.
REQ-029 On a read timeout, the engine SHALL return wb_dat_o=32'hDEAD_BEEF with an ack; an RMW timeout SHALL ack without issuing the write.
REQ-030 ctl_out_valid outside the wait states SHALL be ignored.
REQ-031 If wb_cyc_i drops before the ack, the engine SHALL still complete the controller transaction and suppress wb_ack_o.
REQ-032 The bridge SHALL wait indefinitely while ctl_busy is high (refresh, precharge, activate); the timeout counts only after the request is issued.

Reset
REQ-033 On rst, the bridge SHALL clear wb_ack_o, wb_dat_o, ctl_in_valid, ctl_rw, ctl_addr, ctl_data_in and rd_err to 0, empty the FIFO, zero the timeout counter, and set the state to IDLE.
REQ-034 Reset mid-transaction SHALL abandon the transaction without an ack; pending FIFO entries are discarded.

Verification
REQ-035 Write 0x3800_0010 <- 0x1234_5678 (sel F), with ctl_busy low -> ack 1 cycle after the strobe; ctl_in_valid later with ctl_addr=23'h10, ctl_rw=1, ctl_data_in=0x1234_5678.
REQ-036 Five back-to-back full writes with ctl_busy held high -> four acks, fifth stalled until the first pop; issue order matches push order.
REQ-037 Write A then read A while the FIFO is non-empty -> the read ctl_in_valid follows the write's; read data returns as wb_dat_o with one ack.
REQ-038 Partial write sel=4'b0010, data 0x0000_AB00, memory 0x1122_3344 -> ctl write data 0x1122_AB44, then a single ack.
REQ-039 Read with no ctl_out_valid for 255 cycles -> wb_dat_o=0xDEAD_BEEF, ack, rd_err=1 until rst.
REQ-040 Access 0x3000_0000 -> no ack and no ctl_in_valid.
